rv32i_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues word requests to instruction memory over a req/ready + rvalid handshake. Returned words go into a small instruction buffer, which drives iw_out/pc_out into decode every cycle. Supports downstream stall and a branch/jump redirect from execute, with flush and stale-response discard.

---
 rtl/rv32i_pkg.sv | 17 +
 rtl/rv32i_fetch_buf.sv | 66 ++++++
 rtl/rv32i_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_rv32i_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
package rv32i_pkg;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] iw;
    } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs ahead of decode.
// Flush takes priority over push and pop in the same cycle.
module rv32i_fetch_buf
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    fetch_entry_t  mem_q [DEPTH];

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem handshake, instruction buffer, decode output register.
// Optional macro RV32I_FETCH_MISALIGN_TRAP_EN makes misaligned redirects raise a sticky fetch_fault.
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in,
    input  logic        jmp_en,
    input  logic [31:0] jmp_addr,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic        iw_valid,
    output logic        fetch_fault
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   iw_q, iw_d;
    logic [31:0]   pc_out_q, pc_out_d;
    logic          iw_valid_q, iw_valid_d;
    logic          fault_q, fault_d;
    logic [31:0]   jmp_tgt;
    logic [CW-1:0] buf_count;
    logic [CW:0]   occupancy;
    logic          buf_full, buf_empty, buf_push, buf_pop;
    logic          outstanding, fire;
    fetch_entry_t  buf_wr, buf_rd;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    assign jmp_tgt = jmp_addr;
    assign fault_d = fault_q | (jmp_en & (jmp_addr[1:0] != 2'b00));
`else
    assign jmp_tgt = jmp_addr & 32'hFFFF_FFFC;
    assign fault_d = 1'b0;
`endif

    assign outstanding = (state_q != FETCH);
    assign occupancy   = {1'b0, buf_count} + {{CW{1'b0}}, outstanding};
    // Gated by reset so no request escapes while the block is held in reset.
    assign imem_req    = !reset && !fault_q && (state_q == FETCH)
                         && (occupancy < (CW+1)'(BUF_DEPTH));
    assign imem_addr   = pc_q;
    assign fire        = imem_req && imem_ready;
    assign buf_wr      = {req_pc_q, imem_rdata};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        buf_push = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (fire) begin
                    state_d  = WAIT;
                    pc_d     = pc_q + 32'd4;
                    req_pc_d = pc_q;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    buf_push = !buf_full;
                    state_d  = FETCH;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // A redirect still has to swallow the response of any request already in flight.
        if (jmp_en) begin
            pc_d     = jmp_tgt;
            buf_push = 1'b0;
            if ((state_q == FETCH && fire) || (state_q != FETCH && !imem_rvalid))
                state_d = DROP;
            else
                state_d = FETCH;
        end
    end

    always_comb begin
        iw_d       = iw_q;
        pc_out_d   = pc_out_q;
        iw_valid_d = iw_valid_q;
        buf_pop    = 1'b0;
        if (jmp_en || fault_q) begin
            iw_d       = RV32I_NOP;
            iw_valid_d = 1'b0;
        end else if (stall_in) begin
            iw_d       = iw_q;
        end else if (!buf_empty) begin
            buf_pop    = 1'b1;
            iw_d       = buf_rd.iw;
            pc_out_d   = buf_rd.pc;
            iw_valid_d = 1'b1;
        end else begin
            iw_d       = RV32I_NOP;
            iw_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            iw_q       <= RV32I_NOP;
            pc_out_q   <= RESET_PC;
            iw_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            iw_q       <= iw_d;
            pc_out_q   <= pc_out_d;
            iw_valid_q <= iw_valid_d;
            fault_q    <= fault_d;
        end
    end

    rv32i_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push    (buf_push),
        .pop     (buf_pop),
        .flush   (jmp_en),
        .wr_data (buf_wr),
        .rd_data (buf_rd),
        .count   (buf_count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign iw_out      = iw_q;
    assign pc_out      = pc_out_q;
    assign iw_valid    = iw_valid_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: directed scenarios plus randomized traffic checked against an
// instruction-stream model (sequential PCs from reset or redirect target, word = mem_word(pc)).
module tb_rv32i_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall_in, jmp_en;
    logic [31:0] jmp_addr;
    logic [31:0] iw_out, pc_out;
    logic        iw_valid, fetch_fault;

    logic        req2, ready2;
    logic [31:0] addr2, iw2, pc2;
    logic        valid2, fault2;
    logic        zero_bit;
    logic [31:0] zero_word;

    int          n_asrt = 0;
    int          n_fail = 0;
    int          delivered = 0;
    int          lat = 1;
    logic [31:0] exp_pc;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    rv32i_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall_in    (stall_in),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .iw_out      (iw_out),
        .pc_out      (pc_out),
        .iw_valid    (iw_valid),
        .fetch_fault (fetch_fault)
    );

    rv32i_fetch_unit #(
        .RESET_PC  (32'hFFFF_FFFC),
        .BUF_DEPTH (2)
    ) u_dut_top (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_ready  (ready2),
        .imem_rvalid (zero_bit),
        .imem_rdata  (zero_word),
        .stall_in    (zero_bit),
        .jmp_en      (zero_bit),
        .jmp_addr    (zero_word),
        .iw_out      (iw2),
        .pc_out      (pc2),
        .iw_valid    (valid2),
        .fetch_fault (fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive the memory response for the coming edge, then check the stream model.
    task automatic step();
        logic        fire, p_jmp, p_stall, p_valid, p_hold;
        logic [31:0] fire_addr, p_tgt, p_iw, p_pc, p_addr;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
            end
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end
        fire      = imem_req && imem_ready;
        fire_addr = imem_addr;
        p_jmp     = jmp_en;
        p_tgt     = jmp_addr;
        p_stall   = stall_in;
        p_iw      = iw_out;
        p_pc      = pc_out;
        p_valid   = iw_valid;
        p_hold    = imem_req && !imem_ready && !jmp_en;
        p_addr    = imem_addr;
        @(negedge clk);
        if (fire) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = fire_addr;
        end
        if (p_jmp) begin
            chk("jmp_valid", {31'b0, iw_valid}, 32'd0);
            chk("jmp_nop", iw_out, NOP);
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
            exp_pc = p_tgt;
`else
            exp_pc = p_tgt & 32'hFFFF_FFFC;
`endif
        end else if (p_stall) begin
            chk("stall_iw", iw_out, p_iw);
            chk("stall_pc", pc_out, p_pc);
            chk("stall_valid", {31'b0, iw_valid}, {31'b0, p_valid});
        end else if (iw_valid) begin
            chk("stream_pc", pc_out, exp_pc);
            chk("stream_iw", iw_out, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end else begin
            chk("idle_nop", iw_out, NOP);
        end
        if (p_hold) begin
            chk("req_hold", {31'b0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, p_addr);
        end
    endtask

    initial begin
        int n;
        int fires;
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        stall_in    = 1'b0;
        jmp_en      = 1'b0;
        jmp_addr    = '0;
        ready2      = 1'b0;
        zero_bit    = 1'b0;
        zero_word   = '0;
        pend        = 1'b0;
        pend_cnt    = 0;
        pend_addr   = '0;
        exp_pc      = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_iw", iw_out, NOP);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'b0, iw_valid}, 32'd0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst_pc_top", pc2, 32'hFFFF_FFFC);
        reset = 1'b0;
        @(negedge clk);

        // Memory not ready: request and address must stay put.
        chk("first_addr", imem_addr, 32'h0);
        chk("top_first_addr", addr2, 32'hFFFF_FFFC);
        ready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) begin
                ready2 = 1'b0;
                chk("top_wrap_addr", addr2, 32'h0);
                chk("top_wait_req", {31'b0, req2}, 32'd0);
            end
            chk("notready_req", {31'b0, imem_req}, 32'd1);
            chk("notready_addr", imem_addr, 32'h0);
        end

        // Accept with 1-cycle response: word reaches decode two edges after accept.
        imem_ready = 1'b1;
        step();
        chk("pc_incr", imem_addr, 32'h4);
        imem_ready = 1'b0;
        step();
        chk("latency_early", {31'b0, iw_valid}, 32'd0);
        step();
        chk("first_valid", {31'b0, iw_valid}, 32'd1);
        chk("first_iw", iw_out, 32'h0050_0093);
        chk("first_pc", pc_out, 32'h0);

        // Stall with memory always ready: only BUF_DEPTH words fetched.
        stall_in   = 1'b1;
        imem_ready = 1'b1;
        fires      = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req && imem_ready) fires++;
            step();
        end
        chk("stall_fires", fires, 32'd2);
        chk("stall_req_off", {31'b0, imem_req}, 32'd0);
        chk("stall_pc_held", pc_out, 32'h0);
        stall_in   = 1'b0;
        imem_ready = 1'b0;
        step();
        chk("release_pc0", pc_out, 32'h4);
        step();
        chk("release_pc1", pc_out, 32'h8);

        // Redirect while a request is outstanding.
        lat        = 3;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        jmp_en     = 1'b1;
        jmp_addr   = 32'h0000_0100;
        step();
        jmp_en = 1'b0;
        chk("redir_valid", {31'b0, iw_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_drop_req", {31'b0, imem_req}, 32'd0);
        n = 0;
        while (!imem_req && n < 10) begin step(); n++; end
        chk("redir_req", {31'b0, imem_req}, 32'd1);
        chk("redir_next_addr", imem_addr, 32'h100);
        lat        = 1;
        imem_ready = 1'b1;
        n = 0;
        while (!iw_valid && n < 10) begin step(); n++; end
        chk("redir_target_pc", pc_out, 32'h100);

        // Randomized traffic against the stream model.
        for (int i = 0; i < 400; i++) begin
            stall_in   = ($urandom_range(0, 9) < 3);
            imem_ready = ($urandom_range(0, 9) < 6);
            lat        = $urandom_range(1, 3);
            jmp_en     = ($urandom_range(0, 19) == 0);
            jmp_addr   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            step();
        end
        stall_in   = 1'b0;
        jmp_en     = 1'b0;
        imem_ready = 1'b0;
        lat        = 1;
        chk("progress", {31'b0, (delivered > 50)}, 32'd1);

        // Misaligned redirect.
        jmp_en   = 1'b1;
        jmp_addr = 32'h0000_0102;
        step();
        jmp_en = 1'b0;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("fault_set", {31'b0, fetch_fault}, 32'd1);
            chk("fault_no_req", {31'b0, imem_req}, 32'd0);
            chk("fault_no_valid", {31'b0, iw_valid}, 32'd0);
            step();
        end
`else
        chk("mis_fault", {31'b0, fetch_fault}, 32'd0);
        chk("mis_addr", imem_addr, 32'h100);
        imem_ready = 1'b1;
        n = 0;
        while (!iw_valid && n < 20) begin step(); n++; end
        chk("mis_target_pc", pc_out, 32'h100);
`endif
        imem_ready = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
